// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns a load or store into one word-aligned
// req/ready data-memory transaction. It stalls the pipeline while the
// transaction is outstanding, and it formats load data for MEM/WB.
// Misaligned or illegal accesses are flagged and skipped. A memory that never
// answers is aborted after TIMEOUT request cycles with a bus error.
`timescale 1ns/1ps
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluResultM,
  input  logic [31:0] writeDataM,
  input  logic        holdM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        misalignedM,
  output logic        busErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic        access, is_store, f3_legal, size_bad, flag, go;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, shifted, load_fmt;

  assign access   = memReadM | memWriteM;
  assign is_store = memWriteM;

  // Decode legality and alignment of the access currently presented in MEM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    f3_legal = 1'b0;
    size_bad = 1'b0;
    if (is_store) f3_legal = funct3M inside {3'b000, 3'b001, 3'b010};
    else          f3_legal = funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3M[1:0])
      2'b01:   size_bad = aluResultM[0];
      2'b10:   size_bad = (aluResultM[1:0] != 2'b00);
      default: size_bad = 1'b0;
    endcase
  end

  assign flag        = !f3_legal || size_bad;
  assign go          = (state_q == IDLE) && access && !flag;
  // Gated by reset so a reset mid-transaction releases the pipeline at once.
  assign misalignedM = !reset && (state_q == IDLE) && access && flag;
  assign stallM      = !reset && (go || (state_q == REQ));

  // Byte lanes and replicated write data for the access about to be issued.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = writeDataM;
    case (funct3M[1:0])
      2'b00: begin
        be_new    = 4'b0001 << aluResultM[1:0];
        wdata_new = {4{writeDataM[7:0]}};
      end
      2'b01: begin
        be_new    = aluResultM[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{writeDataM[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = writeDataM;
      end
    endcase
    if (!is_store) wdata_new = 32'd0;
  end

  // Select the addressed byte/half of the returned word and extend it.
  assign shifted = dmem_rdata >> {off_q, 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'd0, shifted[7:0]};
      3'b101:  load_fmt = {16'd0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // Transaction FSM next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {aluResultM[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = funct3M;
          off_d   = aluResultM[1:0];
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (dmem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = load_fmt;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!holdM) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign readDataM  = rdata_q;
  assign busErrM    = err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu. A table of directed transactions is followed
// by randomized ones. A byte-array reference model predicts lanes, load
// results, stall lengths and errors.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReadM, memWriteM, holdM;
  logic [2:0]  funct3M;
  logic [31:0] aluResultM, writeDataM;
  logic [31:0] readDataM;
  logic        stallM, misalignedM, busErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memReadM(memReadM), .memWriteM(memWriteM),
    .funct3M(funct3M), .aluResultM(aluResultM), .writeDataM(writeDataM),
    .holdM(holdM), .readDataM(readDataM), .stallM(stallM),
    .misalignedM(misalignedM), .busErrM(busErrM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  // Memory seen by the DUT (written through its byte enables).
  logic [31:0] mem [64];
  // Reference byte image maintained by the model.
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rdm;
  int delay_cfg  = 0;
  int req_cycles = 0;
  int n_pass = 0, n_total = 0;

  assign dmem_rdata = mem[dmem_addr[7:2]];

  // Ready after delay_cfg request cycles.
  always @(negedge clk) begin
    if (dmem_req) begin
      dmem_ready = (req_cycles == delay_cfg);
      req_cycles++;
    end else begin
      dmem_ready = 1'b0;
      req_cycles = 0;
    end
  end

  always @(posedge clk) begin
    if (dmem_req && dmem_ready && dmem_we)
      for (int l = 0; l < 4; l++)
        if (dmem_be[l]) mem[dmem_addr[7:2]][8*l +: 8] = dmem_wdata[8*l +: 8];
  end

  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          delay, hold;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wdata, rdm;
    bit          err;
  } vec_t;

  function automatic vec_t mk(bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, int d, int h, bit mis,
                              logic [3:0] be, logic [31:0] wdat,
                              logic [31:0] rdm, bit err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd; v.delay = d;
    v.hold = h; v.mis = mis; v.be = be; v.wdata = wdat; v.rdm = rdm; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] = val;
    for (int i = 0; i < 4; i++) ref_mem[4*idx + i] = val[8*i +: 8];
  endtask

  // Reference model.
  function automatic int m_size(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_mis(bit wr, logic [2:0] f3, logic [31:0] a);
    bit legal;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int mask;
    mask = ((1 << m_size(f3)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(bit wr, logic [2:0] f3, logic [31:0] wd);
    logic [31:0] r;
    r = 32'd0;
    if (wr) for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % m_size(f3)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = m_size(f3);
    v  = 32'd0;
    for (int i = 0; i < sz; i++) v |= 32'(ref_mem[(a + i) % 256]) << (8*i);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  // Drive one instruction from IDLE through completion; entered just after a negedge.
  task automatic run_txn(input vec_t v, input string tag);
    int stalls, reqs, exp_stalls;
    bit tmo;
    tmo = v.delay >= TO;
    delay_cfg  = v.delay;
    memReadM   = v.rd;
    memWriteM  = v.wr;
    funct3M    = v.f3;
    aluResultM = v.addr;
    writeDataM = v.wd;
    holdM      = 1'($urandom_range(0, 1));
    #1;
    check({tag, " misalignedM"}, misalignedM, v.mis);
    if (v.mis) begin
      check({tag, " stallM_flagged"}, stallM, 0);
      @(posedge clk); #1;
      check({tag, " no_req"}, dmem_req, 0);
      check({tag, " readDataM_kept"}, readDataM, v.rdm);
    end else begin
      stalls = 0;
      reqs   = 0;
      while (stallM && stalls < 64) begin
        stalls++;
        @(posedge clk); #1;
        if (dmem_req) begin
          reqs++;
          check({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
          check({tag, " be"}, dmem_be, v.be);
          check({tag, " we"}, dmem_we, v.wr);
          check({tag, " wdata"}, dmem_wdata, v.wdata);
          check({tag, " rdm_hold_req"}, readDataM, ref_rdm);
        end
      end
      exp_stalls = tmo ? 1 + TO : 2 + v.delay;
      check({tag, " stall_cycles"}, stalls, exp_stalls);
      check({tag, " req_cycles"}, reqs, exp_stalls - 1);
      check({tag, " readDataM"}, readDataM, v.rdm);
      check({tag, " busErrM"}, busErrM, v.err);
      check({tag, " req_done"}, dmem_req, 0);
      for (int h = 0; h < v.hold; h++) begin
        holdM = 1'b1;
        @(posedge clk); #1;
        check({tag, " hold_stall"}, stallM, 0);
        check({tag, " hold_no_req"}, dmem_req, 0);
        check({tag, " hold_err"}, busErrM, v.err);
        check({tag, " hold_rdm"}, readDataM, v.rdm);
      end
      if (v.wr && !tmo)
        for (int i = 0; i < m_size(v.f3); i++) ref_mem[(v.addr + i) % 256] = v.wd[8*i +: 8];
    end
    ref_rdm   = v.rdm;
    memReadM  = 1'b0;
    memWriteM = 1'b0;
    holdM     = 1'b0;
    @(posedge clk); #1;
    check({tag, " err_cleared"}, busErrM, 0);
    check({tag, " idle_stall"}, stallM, 0);
    @(negedge clk);
  endtask

  vec_t tbl [15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int kind;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    set_word(8, 32'h8001_0000);
    set_word(0, 32'hCAFE_F00D);

    //           rd wr f3 addr    wd             dly hold mis be    wdata          rdm            err
    tbl[0]  = mk(0, 1, 2, 32'h10, 32'h12345678, 0,   0,   0, 4'hF, 32'h12345678, 32'h0,         0);
    tbl[1]  = mk(0, 1, 0, 32'h13, 32'h000000AB, 0,   0,   0, 4'h8, 32'hABABABAB, 32'h0,         0);
    tbl[2]  = mk(1, 0, 0, 32'h13, 32'h0,        0,   0,   0, 4'h8, 32'h0,        32'hFFFFFFAB,  0);
    tbl[3]  = mk(1, 0, 4, 32'h13, 32'h0,        1,   0,   0, 4'h8, 32'h0,        32'h000000AB,  0);
    tbl[4]  = mk(1, 0, 1, 32'h22, 32'h0,        3,   0,   0, 4'hC, 32'h0,        32'hFFFF8001,  0);
    tbl[5]  = mk(1, 0, 2, 32'h06, 32'h0,        0,   0,   1, 4'h0, 32'h0,        32'hFFFF8001,  0);
    tbl[6]  = mk(1, 0, 3, 32'h08, 32'h0,        0,   0,   1, 4'h0, 32'h0,        32'hFFFF8001,  0);
    tbl[7]  = mk(0, 1, 3, 32'h00, 32'h0,        0,   0,   1, 4'h0, 32'h0,        32'hFFFF8001,  0);
    tbl[8]  = mk(0, 1, 1, 32'h22, 32'h1234BEEF, 0,   1,   0, 4'hC, 32'hBEEFBEEF, 32'hFFFF8001,  0);
    tbl[9]  = mk(1, 0, 5, 32'h22, 32'h0,        2,   0,   0, 4'hC, 32'h0,        32'h0000BEEF,  0);
    tbl[10] = mk(1, 0, 2, 32'h20, 32'h0,        100, 1,   0, 4'hF, 32'h0,        32'h0,         1);
    tbl[11] = mk(1, 1, 2, 32'h30, 32'h55AA55AA, 1,   0,   0, 4'hF, 32'h55AA55AA, 32'h0,         0);
    tbl[12] = mk(1, 0, 2, 32'h30, 32'h0,        0,   0,   0, 4'hF, 32'h0,        32'h55AA55AA,  0);
    tbl[13] = mk(1, 0, 1, 32'h21, 32'h0,        0,   0,   1, 4'h0, 32'h0,        32'h55AA55AA,  0);
    tbl[14] = mk(0, 1, 4, 32'h24, 32'h0,        0,   0,   1, 4'h0, 32'h0,        32'h55AA55AA,  0);

    reset = 1'b1; memReadM = 0; memWriteM = 0; holdM = 0;
    funct3M = 0; aluResultM = 0; writeDataM = 0;
    ref_rdm = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req", dmem_req, 0);
    check("reset stall", stallM, 0);
    check("reset readDataM", readDataM, 0);
    check("reset busErrM", busErrM, 0);
    check("reset addr", dmem_addr, 0);
    check("reset be", dmem_be, 0);
    check("reset wdata", dmem_wdata, 0);
    check("reset we", dmem_we, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while a load waits in REQ.
    delay_cfg = 100; memReadM = 1; funct3M = 3'b010; aluResultM = 32'h20;
    @(posedge clk); #1;
    check("rst_mid req_before", dmem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid req", dmem_req, 0);
    check("rst_mid stall", stallM, 0);
    check("rst_mid readDataM", readDataM, 0);
    memReadM = 0;
    @(negedge clk);
    reset = 1'b0;
    ref_rdm = 32'd0;
    run_txn(mk(1, 0, 2, 32'h0, 32'h0, 0, 2, 0, 4'hF, 32'h0, 32'hCAFEF00D, 0), "post_rst");

    // Randomized transactions against the model.
    for (int n = 0; n < 60; n++) begin
      kind    = $urandom_range(0, 2);
      v.rd    = (kind != 1);
      v.wr    = (kind != 0);
      v.f3    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) v.f3 = v.wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + ($urandom_range(0, 1) ? 0 : 4) % 6);
      v.addr  = 32'($urandom_range(0, 255));
      v.wd    = $urandom;
      v.delay = $urandom_range(0, 5);
      v.hold  = $urandom_range(0, 2);
      v.mis   = m_mis(v.wr, v.f3, v.addr);
      v.be    = m_be(v.f3, v.addr);
      v.wdata = m_wdata(v.wr, v.f3, v.wd);
      v.err   = !v.mis && (v.delay >= TO);
      if (v.mis)             v.rdm = ref_rdm;
      else if (v.err)        v.rdm = 32'd0;
      else if (!v.wr)        v.rdm = m_load(v.f3, v.addr);
      else                   v.rdm = ref_rdm;
      run_txn(v, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
